// File: rtl/seq_scan_pkg.sv
// -----------------------------------------------------------------------------
// seq_scan_pkg
//  Shared definitions for the serial edge scanner:
//   - one-hot encodings for the controller (IDLE/SHIFT/DONE)
//   - one-hot encodings for the edge detector (RST/SEEN0/SEEN1)
//   - cnt_width(): number of bits needed to hold a count of 0..width
// -----------------------------------------------------------------------------
package seq_scan_pkg;

   // Controller one-hot encodings, also visible on the debug state port
   localparam logic [2:0] IDLE  = 3'b001;
   localparam logic [2:0] SHIFT = 3'b010;
   localparam logic [2:0] DONE  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_DONE  = DONE
   } ctrl_state_t;

   // Detector one-hot encodings: RST means "no previous bit known"
   typedef enum logic [2:0] {
      DET_RST   = 3'b001,
      DET_SEEN0 = 3'b010,
      DET_SEEN1 = 3'b100
   } det_state_t;

   // A counter that must reach the value 'width' needs clog2(width+1) bits
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/edge01_10_fsm.sv
// -----------------------------------------------------------------------------
// edge01_10_fsm
//  Three-state one-hot Mealy detector for 0->1 and 1->0 transitions on a
//  serial bit stream. The state remembers the previous bit (SEEN0/SEEN1) or
//  that no previous bit exists (RST); the outputs compare that memory with
//  the current bit combinationally.
//
// Ports
//  clk   in   posedge clock
//  rst   in   asynchronous active-high reset, returns to RST
//  clr   in   synchronous clear back to RST (forget history)
//  en    in   advance on this cycle's bit; outputs are forced low when 0
//  x     in   current serial bit
//  y     out  an edge (either direction) is seen on this cycle's bit
//  rise  out  the edge seen is 0->1
// -----------------------------------------------------------------------------
module edge01_10_fsm
   import seq_scan_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic x,
   output logic y,
   output logic rise
);

   det_state_t state;
   logic       state_ok;

   assign state_ok = state inside {DET_RST, DET_SEEN0, DET_SEEN1};

   // History register. clr wins over en so a new word can drop history on
   // the same edge it is loaded; a corrupted encoding falls back to RST
   // because no trustworthy previous bit exists.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DET_RST;
      end else if (clr || !state_ok) begin
         state <= DET_RST;
      end else if (en) begin
         state <= x ? DET_SEEN1 : DET_SEEN0;
      end
   end

   // Mealy outputs: an edge exists only when a previous bit is known and
   // differs from the current one.
   always_comb begin
      y    = 1'b0;
      rise = 1'b0;
      if (en) begin
         case (state)
            DET_SEEN0: begin
               y    = x;
               rise = x;
            end
            DET_SEEN1: begin
               y    = ~x;
            end
            default: begin
               y    = 1'b0;
               rise = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/serial_edge_scan_ctrl.sv
// -----------------------------------------------------------------------------
// serial_edge_scan_ctrl
//  Accepts a parallel word over a valid/ready handshake, shifts it out
//  MSB-first through a Mealy edge detector, counts the edges and returns
//  the count over a second valid/ready handshake. A one-hot controller
//  (IDLE -> SHIFT -> DONE) sequences the work. With 'chain' set on a word
//  and a previous word completed, the first bit is compared against the
//  last bit of that previous word.
//
// Build option
//  SCAN_SPLIT_CNT_EN : adds rise_cnt / fall_cnt ports counting 0->1 and
//                      1->0 edges separately (edge_cnt is their sum).
//
// Ports
//  clk, rst    posedge clock, asynchronous active-high reset
//  in_valid    word offered          in_ready   word can be taken (IDLE)
//  in_data     word, MSB first       chain      keep history for this word
//  out_valid   result held (DONE)    out_ready  consumer takes result
//  edge_cnt    edges in the word
//  ser_bit     bit presented to the detector
//  edge_pulse  detector Mealy output
//  curr_state  controller state (debug)
//  rise_cnt    0->1 edges (option)   fall_cnt   1->0 edges (option)
// -----------------------------------------------------------------------------
module serial_edge_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             chain,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] edge_cnt,
   output logic             ser_bit,
   output logic             edge_pulse,
`ifdef SCAN_SPLIT_CNT_EN
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
`endif
   output logic [2:0]       curr_state
);

   localparam int             IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   ctrl_state_t      state;
   logic [WIDTH-1:0] shreg;
   logic [IDX_W-1:0] bit_idx;
   logic             hist_vld;
   logic             state_ok;
   logic             det_clr;
   logic             det_en;
   logic             det_y;
   logic             det_rise;
   logic             fall_pulse;
   logic [CNT_W-1:0] edge_inc;

   assign curr_state = state;
   assign ser_bit    = shreg[WIDTH-1];
   assign state_ok   = state inside {ST_IDLE, ST_SHIFT, ST_DONE};

   // The detector only advances while bits are being presented. History is
   // dropped when a word is accepted without chaining (or with nothing to
   // chain to), and whenever the controller encoding is corrupted.
   assign det_en  = (state == ST_SHIFT);
   assign det_clr = !state_ok ||
                    ((state == ST_IDLE) && in_valid && !(chain && hist_vld));

   edge01_10_fsm u_detector (
      .clk  (clk),
      .rst  (rst),
      .clr  (det_clr),
      .en   (det_en),
      .x    (ser_bit),
      .y    (det_y),
      .rise (det_rise)
   );

   // Split the detector output into its two directions; the total is the
   // sum of both so edge_cnt always equals rise + fall.
   assign edge_pulse = det_y;
   assign fall_pulse = det_y & ~det_rise;
   assign edge_inc   = CNT_W'(det_rise) + CNT_W'(fall_pulse);

   // Controller, shift register, bit index and counters. in_ready and
   // out_valid are registered alongside the state so they change on the
   // same edge as the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         shreg     <= '0;
         bit_idx   <= '0;
         edge_cnt  <= '0;
         hist_vld  <= 1'b0;
`ifdef SCAN_SPLIT_CNT_EN
         rise_cnt  <= '0;
         fall_cnt  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  shreg     <= in_data;
                  bit_idx   <= '0;
                  edge_cnt  <= '0;
`ifdef SCAN_SPLIT_CNT_EN
                  rise_cnt  <= '0;
                  fall_cnt  <= '0;
`endif
                  state     <= ST_SHIFT;
                  in_ready  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               shreg    <= {shreg[WIDTH-2:0], 1'b0};
               bit_idx  <= bit_idx + IDX_W'(1);
               edge_cnt <= edge_cnt + edge_inc;
`ifdef SCAN_SPLIT_CNT_EN
               rise_cnt <= rise_cnt + CNT_W'(det_rise);
               fall_cnt <= fall_cnt + CNT_W'(fall_pulse);
`endif
               if (bit_idx == LAST_IDX) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  hist_vld  <= 1'b1;
               end
            end
            ST_DONE: begin
               // No bypass: a word offered now is taken on the IDLE cycle
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               hist_vld  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_edge_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_edge_scan_ctrl
//  Directed bench for serial_edge_scan_ctrl (WIDTH=8). A word-level model
//  tracks which phase of a transaction the scanner is in and what every bit
//  and edge must be; a negedge process compares the DUT against it each
//  cycle. The directed sequence pins the model with hand-computed counts,
//  latency, hold, back-to-back and mid-word reset cases.
// -----------------------------------------------------------------------------
module tb_serial_edge_scan_ctrl;

   localparam int W     = 8;
   localparam int CNT_W = 4;
   localparam int LAT   = W + 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             chain;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] edge_cnt;
   logic             ser_bit;
   logic             edge_pulse;
   logic [2:0]       curr_state;
`ifdef SCAN_SPLIT_CNT_EN
   logic [CNT_W-1:0] rise_cnt;
   logic [CNT_W-1:0] fall_cnt;
`endif

   int checks = 0;
   int passes = 0;

   serial_edge_scan_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .chain      (chain),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .edge_cnt   (edge_cnt),
      .ser_bit    (ser_bit),
      .edge_pulse (edge_pulse),
`ifdef SCAN_SPLIT_CNT_EN
      .rise_cnt   (rise_cnt),
      .fall_cnt   (fall_cnt),
`endif
      .curr_state (curr_state)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, exp);
      else
         passes++;
   endtask

   // Edge counts for a whole word given the previous bit (-1 = none)
   function automatic void scanWord(input logic [W-1:0] w, input int prev,
                                    output int e, output int r, output int f);
      int p;
      p = prev;
      e = 0; r = 0; f = 0;
      for (int i = W - 1; i >= 0; i--) begin
         int b;
         b = int'(w[i]);
         if (p >= 0 && b != p) begin
            e++;
            if (b == 1) r++;
            else        f++;
         end
         p = b;
      end
   endfunction

   // Model: phase 0 = waiting for a word, 1..W = presenting bit phase-1,
   // W+1 = result held. History is the last bit of the last finished word.
   int           m_phase = 0;
   logic [W-1:0] m_word  = '0;
   int           m_prev0 = -1;
   bit           m_hist  = 1'b0;
   int           m_last  = 0;
   int           m_e = 0, m_r = 0, m_f = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_hist  = 1'b0;
         checkOutput("reset_in_ready",   in_ready,   1);
         checkOutput("reset_out_valid",  out_valid,  0);
         checkOutput("reset_state",      curr_state, 3'b001);
         checkOutput("reset_ser_bit",    ser_bit,    0);
         checkOutput("reset_edge_pulse", edge_pulse, 0);
         checkOutput("reset_edge_cnt",   edge_cnt,   0);
`ifdef SCAN_SPLIT_CNT_EN
         checkOutput("reset_rise_cnt",   rise_cnt,   0);
         checkOutput("reset_fall_cnt",   fall_cnt,   0);
`endif
      end else if (m_phase == 0) begin
         checkOutput("idle_in_ready",   in_ready,   1);
         checkOutput("idle_out_valid",  out_valid,  0);
         checkOutput("idle_state",      curr_state, 3'b001);
         checkOutput("idle_edge_pulse", edge_pulse, 0);
         if (in_valid) begin
            m_word  = in_data;
            m_prev0 = (chain && m_hist) ? m_last : -1;
            scanWord(m_word, m_prev0, m_e, m_r, m_f);
            m_phase = 1;
         end
      end else if (m_phase <= W) begin
         int i, b, p;
         i = m_phase - 1;
         b = int'(m_word[W-1-i]);
         p = (i == 0) ? m_prev0 : int'(m_word[W-i]);
         checkOutput("shift_in_ready",   in_ready,   0);
         checkOutput("shift_out_valid",  out_valid,  0);
         checkOutput("shift_state",      curr_state, 3'b010);
         checkOutput("shift_ser_bit",    ser_bit,    b);
         checkOutput("shift_edge_pulse", edge_pulse, (p >= 0 && p != b) ? 1 : 0);
         if (m_phase == W) begin
            m_phase = W + 1;
            m_hist  = 1'b1;
            m_last  = int'(m_word[0]);
         end else begin
            m_phase++;
         end
      end else begin
         checkOutput("done_in_ready",   in_ready,   0);
         checkOutput("done_out_valid",  out_valid,  1);
         checkOutput("done_state",      curr_state, 3'b100);
         checkOutput("done_edge_pulse", edge_pulse, 0);
         checkOutput("done_edge_cnt",   edge_cnt,   m_e);
`ifdef SCAN_SPLIT_CNT_EN
         checkOutput("done_rise_cnt",   rise_cnt,   m_r);
         checkOutput("done_fall_cnt",   fall_cnt,   m_f);
`endif
         if (out_ready) m_phase = 0;
      end
   end

   // Offer a word just after a rising edge
   task automatic applyStimulus(input logic [W-1:0] w, input logic ch);
      @(posedge clk);
      #1;
      in_data  = w;
      chain    = ch;
      in_valid = 1'b1;
   endtask

   // Wait (bounded) until the offered word is taken, then withdraw it
   task automatic waitAccept(input string name);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({name, "_accept"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count clocks from the accept edge to out_valid and check the result
   task automatic waitResult(input string name, input int exp_e, input int exp_r, input int exp_f);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (out_valid !== 1'b1 && lat < 40);
      checkOutput({name, "_out_valid"}, out_valid, 1);
      checkOutput({name, "_latency"},   lat,       LAT);
      checkOutput({name, "_edge_cnt"},  edge_cnt,  exp_e);
`ifdef SCAN_SPLIT_CNT_EN
      checkOutput({name, "_rise_cnt"},  rise_cnt,  exp_r);
      checkOutput({name, "_fall_cnt"},  fall_cnt,  exp_f);
`else
      if (exp_r + exp_f != exp_e)
         $display("[TB] note %s: rise/fall table entry inconsistent", name);
`endif
   endtask

   // Called on the negedge where out_valid and out_ready are both high
   task automatic checkHandshake(input string name);
      checkOutput({name, "_ready_before"}, in_ready, 0);
      @(negedge clk);
      checkOutput({name, "_ready_after"},  in_ready, 1);
   endtask

   initial begin
      bit seen_valid;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      chain     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Alternating bits: 7 edges, 4 rising / 3 falling
      applyStimulus(8'h55, 1'b0); waitAccept("w55"); waitResult("w55", 7, 4, 3);
      // Constant word and a single step
      applyStimulus(8'hFF, 1'b0); waitAccept("wFF"); waitResult("wFF", 0, 0, 0);
      applyStimulus(8'h0F, 1'b0); waitAccept("w0F"); waitResult("w0F", 1, 1, 0);

      // 00 then 80: chained sees the 0->1 across the boundary
      applyStimulus(8'h00, 1'b0); waitAccept("c00");   waitResult("c00", 0, 0, 0);
      applyStimulus(8'h80, 1'b1); waitAccept("c80");   waitResult("c80", 2, 1, 1);
      applyStimulus(8'h00, 1'b0); waitAccept("n00");   waitResult("n00", 0, 0, 0);
      applyStimulus(8'h80, 1'b0); waitAccept("n80");   waitResult("n80", 1, 0, 1);

      // Back-to-back chained words, in_ready back one clock after handshake
      applyStimulus(8'hA5, 1'b1); waitAccept("bA5");   waitResult("bA5", 7, 4, 3);
      checkHandshake("b2b");
      applyStimulus(8'h3C, 1'b1); waitAccept("b3C");   waitResult("b3C", 3, 1, 2);

      // Consumer stalls 5 clocks while another word is offered
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(8'h0F, 1'b0); waitAccept("holdA"); waitResult("holdA", 1, 1, 0);
      @(posedge clk);
      #1;
      in_data  = 8'h3D;
      chain    = 1'b0;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("hold_out_valid", out_valid, 1);
         checkOutput("hold_edge_cnt",  edge_cnt,  1);
         checkOutput("hold_in_ready",  in_ready,  0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitAccept("holdB"); waitResult("holdB", 3, 2, 1);

      // Reset during bit 3 of a chained word: abandoned, history lost
      applyStimulus(8'hFF, 1'b1); waitAccept("rstw");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen_valid = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen_valid = 1'b1;
      end
      checkOutput("rst_no_out_valid", seen_valid, 0);
      checkOutput("rst_idle_state",   curr_state, 3'b001);
      applyStimulus(8'h7F, 1'b1); waitAccept("after_rst"); waitResult("after_rst", 1, 1, 0);

      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
